// File: rtl/step_response_monitor.sv
// Step-response monitor: times the first and second threshold crossings of a
// sampled filter output after a stimulus edge and reports them via valid/ready.
module step_response_monitor #(
    parameter int W       = 16,
    parameter int TIMEOUT = 1023,
    localparam int CW     = $clog2(TIMEOUT + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                step_start,
    input  logic                step_rise,
    input  logic signed [W-1:0] thr_lo,
    input  logic signed [W-1:0] thr_hi,
    input  logic                sample_valid,
    input  logic signed [W-1:0] sample,
    output logic                busy,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [CW-1:0]       t_delay,
    output logic [CW-1:0]       t_edge,
    output logic                timeout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT1  = 2'd1,
        WAIT2  = 2'd2,
        REPORT = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  rise_q, rise_d;
    logic signed [W-1:0]   lo_q, lo_d;
    logic signed [W-1:0]   hi_q, hi_d;
    logic [CW-1:0]         t_delay_q, t_delay_d;
    logic [CW-1:0]         t_edge_q, t_edge_d;
    logic                  timeout_q, timeout_d;

    logic [CW-1:0]         cnt_inc;
    logic                  at_limit;
    logic                  c1;
    logic                  c2;

    // First crossing: leaving the starting rail (lo for rising, hi for falling).
    function automatic logic cross_first(input logic rise,
                                         input logic signed [W-1:0] s,
                                         input logic signed [W-1:0] lo,
                                         input logic signed [W-1:0] hi);
        return rise ? (s >= lo) : (s <= hi);
    endfunction

    function automatic logic cross_second(input logic rise,
                                          input logic signed [W-1:0] s,
                                          input logic signed [W-1:0] lo,
                                          input logic signed [W-1:0] hi);
        return rise ? (s >= hi) : (s <= lo);
    endfunction

    assign cnt_inc  = cnt_q + CW'(1);
    assign at_limit = (cnt_inc == CW'(TIMEOUT));
    assign c1       = cross_first(rise_q, sample, lo_q, hi_q);
    assign c2       = cross_second(rise_q, sample, lo_q, hi_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rise_d    = rise_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        t_delay_d = t_delay_q;
        t_edge_d  = t_edge_q;
        timeout_d = timeout_q;

        unique case (state_q)
            IDLE, WAIT1, WAIT2: begin
                // A new step always (re)starts the measurement; its own sample is skipped.
                if (step_start) begin
                    state_d   = WAIT1;
                    cnt_d     = '0;
                    rise_d    = step_rise;
                    lo_d      = thr_lo;
                    hi_d      = thr_hi;
                    t_delay_d = '0;
                    t_edge_d  = '0;
                    timeout_d = 1'b0;
                end else if (sample_valid && state_q == WAIT1) begin
                    cnt_d = cnt_inc;
                    if (c1 && c2) begin
                        t_delay_d = cnt_inc;
                        t_edge_d  = '0;
                        state_d   = REPORT;
                    end else if (at_limit) begin
                        t_delay_d = '0;
                        t_edge_d  = '0;
                        timeout_d = 1'b1;
                        state_d   = REPORT;
                    end else if (c1) begin
                        t_delay_d = cnt_inc;
                        state_d   = WAIT2;
                    end
                end else if (sample_valid && state_q == WAIT2) begin
                    cnt_d = cnt_inc;
                    if (c2) begin
                        t_edge_d = cnt_inc - t_delay_q;
                        state_d  = REPORT;
                    end else if (at_limit) begin
                        t_edge_d  = '0;
                        timeout_d = 1'b1;
                        state_d   = REPORT;
                    end
                end
            end
            REPORT: begin
                if (res_ready) begin
                    state_d   = IDLE;
                    timeout_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rise_q    <= 1'b0;
            lo_q      <= '0;
            hi_q      <= '0;
            t_delay_q <= '0;
            t_edge_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rise_q    <= rise_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            t_delay_q <= t_delay_d;
            t_edge_q  <= t_edge_d;
            timeout_q <= timeout_d;
        end
    end

    assign busy      = (state_q == WAIT1) || (state_q == WAIT2);
    assign res_valid = (state_q == REPORT);
    assign t_delay   = t_delay_q;
    assign t_edge    = t_edge_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_step_response_monitor.sv
// Bench for step_response_monitor: default-TIMEOUT and TIMEOUT=50 instances
// checked against a sequence-level reference of the crossing rules.
module tb_step_response_monitor;

    localparam int W  = 16;
    localparam int TA = 1023;
    localparam int TB = 50;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic                st_a, st_b, step_rise, sample_valid, res_ready;
    logic signed [W-1:0] thr_lo, thr_hi, sample;
    logic                busy_a, rv_a, to_a;
    logic [9:0]          td_a, te_a;
    logic                busy_b, rv_b, to_b;
    logic [5:0]          td_b, te_b;

    step_response_monitor #(.W(W), .TIMEOUT(TA)) dut_a (
        .clk(clk), .rst_n(rst_n), .step_start(st_a), .step_rise(step_rise),
        .thr_lo(thr_lo), .thr_hi(thr_hi), .sample_valid(sample_valid), .sample(sample),
        .busy(busy_a), .res_valid(rv_a), .res_ready(res_ready),
        .t_delay(td_a), .t_edge(te_a), .timeout(to_a)
    );

    step_response_monitor #(.W(W), .TIMEOUT(TB)) dut_b (
        .clk(clk), .rst_n(rst_n), .step_start(st_b), .step_rise(step_rise),
        .thr_lo(thr_lo), .thr_hi(thr_hi), .sample_valid(sample_valid), .sample(sample),
        .busy(busy_b), .res_valid(rv_b), .res_ready(res_ready),
        .t_delay(td_b), .t_edge(te_b), .timeout(to_b)
    );

    bit          sel;
    bit          cur_rise;
    logic [31:0] m_busy, m_rv, m_to, m_td, m_te, o_busy;
    assign m_busy = sel ? 32'(busy_b) : 32'(busy_a);
    assign o_busy = sel ? 32'(busy_a) : 32'(busy_b);
    assign m_rv   = sel ? 32'(rv_b)   : 32'(rv_a);
    assign m_to   = sel ? 32'(to_b)   : 32'(to_a);
    assign m_td   = sel ? 32'(td_b)   : 32'(td_a);
    assign m_te   = sel ? 32'(te_b)   : 32'(te_a);

    int nchk = 0;
    int nerr = 0;
    int exp_d, exp_e, exp_to;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nchk++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int sat(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Reference: walk the accepted-sample sequence and apply the crossing rules.
    function automatic void ref_eval(input bit rise, input int lo, input int hi, input int tlim,
                                     input int s[$], output int d, output int e,
                                     output int to, output int dn);
        int first;
        d = 0; e = 0; to = 0; dn = 0; first = 0;
        for (int n = 1; n <= s.size(); n++) begin
            bit c1, c2;
            c1 = rise ? (s[n-1] >= lo) : (s[n-1] <= hi);
            c2 = rise ? (s[n-1] >= hi) : (s[n-1] <= lo);
            if (first == 0) begin
                if (c1 && c2) begin d = n; dn = n; return; end
                if (n == tlim) begin to = 1; dn = n; return; end
                if (c1) first = n;
            end else begin
                if (c2) begin d = first; e = n - first; dn = n; return; end
                if (n == tlim) begin d = first; to = 1; dn = n; return; end
            end
        end
    endfunction

    task automatic build(input int mode, input bit rise, input int lo, input int hi,
                         input int n, output int s[$]);
        int v;
        s = {};
        v = rise ? lo - 3000 : hi + 3000;
        for (int k = 1; k <= n; k++) begin
            case (mode)
                0: s.push_back(sat(100 * k));
                1: s.push_back(sat(10000 - 100 * k));
                2: s.push_back(k < 5 ? 0 : 20000);
                3: s.push_back(5000);
                4: s.push_back(0);
                default: begin
                    v = rise ? v + int'($urandom_range(0, 800)) - 100
                             : v + 100 - int'($urandom_range(0, 800));
                    v = sat(v);
                    s.push_back(v);
                end
            endcase
        end
    endtask

    task automatic start_step(input bit which, input bit rise, input int lo, input int hi);
        sel          = which;
        cur_rise     = rise;
        step_rise    = rise;
        thr_lo       = W'(lo);
        thr_hi       = W'(hi);
        sample_valid = 1'b1;
        sample       = rise ? 16'sh7fff : 16'sh8000;
        if (which) st_b = 1'b1; else st_a = 1'b1;
        tick();
        st_a = 1'b0;
        st_b = 1'b0;
        chk("busy_after_start", m_busy, 32'd1);
        chk("other_inst_idle", o_busy, 32'd0);
    endtask

    // Drive one accepted sample (optionally preceded by an idle gap cycle) with
    // scrambled threshold/direction inputs that must be ignored.
    task automatic feed(input int v, input bit gap);
        if (gap) begin
            sample_valid = 1'b0;
            sample       = cur_rise ? 16'sh7fff : 16'sh8000;
            tick();
        end
        sample_valid = 1'b1;
        sample       = W'(v);
        thr_lo       = W'($urandom);
        thr_hi       = W'($urandom);
        step_rise    = 1'($urandom);
    endtask

    task automatic measure(input bit which, input bit rise, input int lo, input int hi,
                           input int mode, input int gapm, input string tag);
        int s[$];
        int dn;
        int tlim;
        tlim = which ? TB : TA;
        build(mode, rise, lo, hi, tlim, s);
        ref_eval(rise, lo, hi, tlim, s, exp_d, exp_e, exp_to, dn);
        start_step(which, rise, lo, hi);
        for (int k = 1; k <= dn; k++) begin
            bit g;
            g = (gapm == 1 && k > 1) || (gapm == 2 && $urandom_range(0, 2) == 0);
            feed(s[k-1], g);
            if (k == dn) begin
                chk($sformatf("%s_not_early", tag), m_rv, 32'd0);
                chk($sformatf("%s_busy_before", tag), m_busy, 32'd1);
            end
            tick();
        end
        sample_valid = 1'b0;
        chk($sformatf("%s_res_valid", tag), m_rv, 32'd1);
        chk($sformatf("%s_busy_after", tag), m_busy, 32'd0);
        chk($sformatf("%s_t_delay", tag), m_td, 32'(exp_d));
        chk($sformatf("%s_t_edge", tag), m_te, 32'(exp_e));
        chk($sformatf("%s_timeout", tag), m_to, 32'(exp_to));
    endtask

    task automatic release_res();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("released_res_valid", m_rv, 32'd0);
        chk("released_busy", m_busy, 32'd0);
        chk("released_timeout", m_to, 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired nchk=%0d", nchk);
        $fatal(1, "watchdog");
    end

    initial begin
        int s_dummy[$];
        rst_n = 1'b0; st_a = 1'b0; st_b = 1'b0; step_rise = 1'b0;
        thr_lo = '0; thr_hi = '0; sample_valid = 1'b0; sample = '0; res_ready = 1'b0;
        sel = 1'b0; cur_rise = 1'b0;
        tick(); tick();
        chk("rst_busy", m_busy, 32'd0);
        chk("rst_res_valid", m_rv, 32'd0);
        chk("rst_timeout", m_to, 32'd0);
        chk("rst_t_delay", m_td, 32'd0);
        chk("rst_t_edge", m_te, 32'd0);
        rst_n = 1'b1;
        tick();

        measure(0, 1, 1000, 9000, 0, 0, "rise_ramp");
        chk("rise_ramp_td_lit", m_td, 32'd10);
        chk("rise_ramp_te_lit", m_te, 32'd80);
        release_res();

        measure(0, 0, 1000, 9000, 1, 1, "fall_gap");
        chk("fall_gap_td_lit", m_td, 32'd10);
        chk("fall_gap_te_lit", m_te, 32'd80);
        release_res();

        measure(0, 1, 1000, 9000, 2, 0, "jump");
        chk("jump_td_lit", m_td, 32'd5);
        chk("jump_te_lit", m_te, 32'd0);
        release_res();

        measure(1, 1, 1000, 9000, 3, 0, "to_const5000");
        chk("to_const5000_td_lit", m_td, 32'd1);
        chk("to_const5000_to_lit", m_to, 32'd1);
        release_res();
        measure(1, 1, 1000, 9000, 4, 0, "to_const0");
        chk("to_const0_to_lit", m_to, 32'd1);
        release_res();
        measure(1, 1, 1000, 9000, 0, 0, "to_ramp_wait2");
        release_res();

        // Result held under backpressure; a step_start during REPORT is ignored.
        measure(0, 1, 1000, 9000, 2, 0, "hold");
        for (int i = 0; i < 20; i++) begin
            sample_valid = 1'b1;
            sample       = W'($urandom);
            st_a         = (i == 10);
            tick();
            st_a = 1'b0;
            chk("hold_res_valid", m_rv, 32'd1);
            chk("hold_t_delay", m_td, 32'(exp_d));
            chk("hold_t_edge", m_te, 32'(exp_e));
        end
        sample_valid = 1'b0;
        release_res();

        // Restart at n=30 while in WAIT2; only the new step is measured.
        build(0, 1, 1000, 9000, 30, s_dummy);
        start_step(0, 1, 1000, 9000);
        for (int k = 0; k < 30; k++) begin
            feed(s_dummy[k], 1'b0);
            tick();
        end
        chk("restart_busy_n30", m_busy, 32'd1);
        measure(0, 0, 2000, 7000, 1, 0, "restart");
        release_res();

        // Asynchronous reset mid-WAIT2, asserted between clock edges.
        start_step(0, 1, 1000, 9000);
        for (int k = 0; k < 20; k++) begin
            feed(s_dummy[k], 1'b0);
            tick();
        end
        sample_valid = 1'b0;
        chk("pre_areset_busy", m_busy, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("areset_busy", m_busy, 32'd0);
        chk("areset_res_valid", m_rv, 32'd0);
        chk("areset_t_delay", m_td, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        measure(0, 1, 1000, 9000, 0, 0, "post_reset");
        release_res();

        for (int r = 0; r < 8; r++) begin
            int lo, hi;
            lo = int'($urandom_range(0, 10000)) - 5000;
            hi = lo + int'($urandom_range(0, 8000));
            measure(r[0], 1'($urandom_range(0, 1)), lo, hi, 5, 2, $sformatf("rand%0d", r));
            release_res();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
